// File: rtl/cache_data_array.sv
// 1-read/1-write cache storage array with per-byte write enables and a
// self-clearing sweep that zeroes every entry after reset or on request.
module cache_data_array #(
  parameter  int WIDTH = 128,
  parameter  int DEPTH = 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  output logic               busy,
  input  logic               write,
  input  logic [IDX_W-1:0]   windex,
  input  logic [WIDTH/8-1:0] wmask,
  input  logic [WIDTH-1:0]   datain,
  input  logic [IDX_W-1:0]   rindex,
  output logic [WIDTH-1:0]   dataout
);

  localparam logic [0:0]       ST_CLEAR = 1'b0;
  localparam logic [0:0]       ST_READY = 1'b1;
  localparam int unsigned      NBYTES   = WIDTH / 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  logic [0:0]       r_state;
  logic [IDX_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_busy;
  logic             w_last;

  assign w_busy = (r_state == ST_CLEAR);
  assign w_last = (r_cnt == LAST_IDX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= ST_READY;
          end else begin
            r_cnt <= r_cnt + IDX_W'(1);
          end
        end
        default: begin
          if (clear) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
          end
        end
      endcase
    end
  end

  // Storage has no reset; the sweep owns the write port while busy, so
  // writes and clears arriving during a sweep are simply dropped.
  always_ff @(posedge clk) begin
    if (w_busy) begin
      r_mem[r_cnt] <= '0;
    end else if (write) begin
      for (int unsigned b = 0; b < NBYTES; b++) begin
        if (wmask[b]) begin
          r_mem[windex][8*b +: 8] <= datain[8*b +: 8];
        end
      end
    end
  end

  assign busy    = w_busy;
  assign dataout = w_busy ? '0 : r_mem[rindex];

endmodule
